// File: rtl/lw_sha_msg_padder.sv
// SHA-256 message padder: packs a 32-bit big-endian word stream into 16-word
// blocks, adding the 0x80 marker, zero fill, and the 64-bit bit length.
module lw_sha_msg_padder (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_in_data,
  input  logic              i_in_last,
  input  logic [2:0]        i_in_nbytes,
  output logic              o_blk_valid,
  input  logic              i_blk_ready,
  output logic [15:0][31:0] o_blk_words,
  output logic              o_blk_last
);

  typedef enum logic [1:0] {FILL, MARK, LEN, HOLD} st_t;

  st_t               r_st, w_st_nxt, r_next_st, w_next_st_nxt;
  logic [15:0][31:0] r_w;
  logic [3:0]        r_idx;
  logic [63:0]       r_len;
  logic              r_last;
  logic              w_acc;
  logic [2:0]        w_n;
  logic [31:0]       w_tail;

  assign o_in_ready  = (r_st == FILL);
  assign o_blk_valid = (r_st == HOLD);
  assign o_blk_last  = o_blk_valid & r_last;
  assign o_blk_words = r_w;
  assign w_acc       = i_in_valid & o_in_ready;
  assign w_n         = (i_in_nbytes > 3'd4) ? 3'd4 : i_in_nbytes;

  // Final word with trailing bytes masked and the marker in byte position n
  always_comb begin
    w_tail = i_in_data;
    case (w_n)
      3'd0:    w_tail = 32'h8000_0000;
      3'd1:    w_tail = {i_in_data[31:24], 8'h80, 16'h0000};
      3'd2:    w_tail = {i_in_data[31:16], 8'h80, 8'h00};
      3'd3:    w_tail = {i_in_data[31:8], 8'h80};
      default: w_tail = i_in_data;
    endcase
  end

  always_comb begin
    w_st_nxt      = r_st;
    w_next_st_nxt = r_next_st;
    case (r_st)
      FILL: if (w_acc) begin
        if (!i_in_last) begin
          if (r_idx == 4'd15) begin
            w_st_nxt      = HOLD;
            w_next_st_nxt = FILL;
          end
        end else if (w_n != 3'd4) begin
          if (r_idx <= 4'd13) w_st_nxt = LEN;
          else begin
            w_st_nxt      = HOLD;
            w_next_st_nxt = LEN;
          end
        end else if (r_idx == 4'd15) begin
          w_st_nxt      = HOLD;
          w_next_st_nxt = MARK;
        end else begin
          w_st_nxt = MARK;
        end
      end
      MARK: begin
        if (r_idx <= 4'd13) w_st_nxt = LEN;
        else begin
          w_st_nxt      = HOLD;
          w_next_st_nxt = LEN;
        end
      end
      LEN:  w_st_nxt = HOLD;
      HOLD: if (i_blk_ready) w_st_nxt = r_last ? FILL : r_next_st;
      default: w_st_nxt = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_st      <= FILL;
      r_next_st <= FILL;
      r_w       <= '0;
      r_idx     <= 4'd0;
      r_len     <= 64'd0;
      r_last    <= 1'b0;
    end else begin
      r_st      <= w_st_nxt;
      r_next_st <= w_next_st_nxt;
      case (r_st)
        FILL: if (w_acc) begin
          if (!i_in_last) begin
            r_w[r_idx] <= i_in_data;
            r_len      <= r_len + 64'd32;
            if (r_idx != 4'd15) r_idx <= r_idx + 4'd1;
          end else begin
            r_w[r_idx] <= w_tail;
            r_len      <= r_len + {58'd0, w_n, 3'd0};
            if (w_n == 3'd4 && r_idx != 4'd15) r_idx <= r_idx + 4'd1;
          end
        end
        MARK: r_w[r_idx] <= 32'h8000_0000;
        LEN: begin
          r_w[14] <= r_len[63:32];
          r_w[15] <= r_len[31:0];
          r_last  <= 1'b1;
        end
        HOLD: if (i_blk_ready) begin
          // Clearing on handoff provides the zero fill for the next block
          r_w   <= '0;
          r_idx <= 4'd0;
          if (r_last) begin
            r_len  <= 64'd0;
            r_last <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lw_sha_msg_padder.sv
// Bench for lw_sha_msg_padder: byte-level padding model feeds a block
// scoreboard; a monitor applies backpressure and checks stalls.
module tb_lw_sha_msg_padder;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [31:0]       in_data = '0;
  logic              in_last = 1'b0;
  logic [2:0]        in_nbytes = '0;
  logic              blk_valid;
  logic              blk_ready;
  logic [15:0][31:0] blk_words;
  logic              blk_last;

  always #5 clk = ~clk;

  lw_sha_msg_padder dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_last(in_last), .i_in_nbytes(in_nbytes),
    .o_blk_valid(blk_valid), .i_blk_ready(blk_ready),
    .o_blk_words(blk_words), .o_blk_last(blk_last)
  );

  typedef struct { int len; int base; int stall; int nblk; bit over; } vec_t;
  typedef struct { logic [15:0][31:0] w; logic last; } blk_t;

  blk_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   stall  = 0;
  int   nblk   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference padding built byte by byte, then sliced into blocks
  task automatic push_model(input int len, input int base);
    byte unsigned p[$];
    longint unsigned bits;
    blk_t b;
    for (int i = 0; i < len; i++) p.push_back(8'((base + i) & 255));
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = longint'(len) * 8;
    for (int k = 7; k >= 0; k--) p.push_back(8'(bits >> (8 * k)));
    for (int bi = 0; bi < p.size() / 64; bi++) begin
      for (int j = 0; j < 16; j++)
        b.w[j] = {p[bi*64+4*j], p[bi*64+4*j+1], p[bi*64+4*j+2], p[bi*64+4*j+3]};
      b.last = (bi == p.size() / 64 - 1);
      q.push_back(b);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
    t = 0;
    while (!in_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) chk("in_ready_timeout", 512'(in_ready), 512'(1));
    @(posedge clk);
  endtask

  task automatic send_msg(input int len, input int base, input bit over);
    int nw, nb;
    logic [31:0] d;
    nw = (len == 0) ? 1 : (len + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < 4; j++)
        d[31-8*j -: 8] = (4*k + j < len) ? 8'((base + 4*k + j) & 255) : 8'hAA;
      if (k == nw - 1) begin
        nb = len - 4*k;
        if (over && nb == 4) nb = 7;
        send_word(d, 1'b1, 3'(nb));
      end else begin
        send_word(d, 1'b0, 3'($urandom_range(0, 7)));
      end
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic lat_check(input string name, input int exp);
    int c;
    c = 1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    while (!blk_valid && c < 20) begin @(negedge clk); c++; end
    chk(name, 512'(c), 512'(exp));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("drain_timeout", 512'(q.size()), 512'(0));
    repeat (4) @(negedge clk);
  endtask

  task automatic reset_check();
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_blk_last",  512'(blk_last),  512'(0));
    chk("rst_in_ready",  512'(in_ready),  512'(1));
    chk("rst_blk_words", 512'(blk_words), 512'(0));
  endtask

  // Monitor: stall each block for `stall` cycles, then take it and score it
  initial begin
    int sc;
    logic [15:0][31:0] snap_w;
    logic snap_l;
    blk_t e;
    blk_ready = 1'b0;
    sc = 0;
    forever begin
      @(negedge clk);
      if (blk_valid === 1'b1) begin
        if (sc < stall) begin
          if (sc == 0) begin
            snap_w = blk_words; snap_l = blk_last;
          end else begin
            chk("stall_words", 512'(blk_words), 512'(snap_w));
            chk("stall_last",  512'(blk_last),  512'(snap_l));
          end
          chk("stall_in_ready", 512'(in_ready), 512'(0));
          sc++;
          blk_ready = 1'b0;
        end else begin
          if (q.size() == 0) begin
            chk("unexpected_block", 512'(blk_words), 512'(0));
          end else begin
            e = q.pop_front();
            chk("blk_words", 512'(blk_words), 512'(e.w));
            chk("blk_last",  512'(blk_last),  512'(e.last));
          end
          nblk++;
          sc = 0;
          blk_ready = 1'b1;
        end
      end else begin
        blk_ready = 1'b0;
      end
    end
  end

  initial begin
    vec_t tbl[8];
    int   n0;
    tbl[0] = '{len:3,   base:'h61, stall:0, nblk:1, over:0};
    tbl[1] = '{len:0,   base:'h00, stall:0, nblk:1, over:0};
    tbl[2] = '{len:55,  base:'h10, stall:1, nblk:1, over:0};
    tbl[3] = '{len:56,  base:'h20, stall:2, nblk:2, over:0};
    tbl[4] = '{len:64,  base:'h30, stall:5, nblk:2, over:1};
    tbl[5] = '{len:100, base:'h40, stall:1, nblk:2, over:0};
    tbl[6] = '{len:123, base:'h50, stall:0, nblk:3, over:0};
    tbl[7] = '{len:4,   base:'h70, stall:3, nblk:1, over:0};

    reset_check();

    // "abc": marker fits, block two cycles after the handshake
    stall = 0;
    push_model(3, 'h61);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    lat_check("lat_abc", 2);
    drain();

    // Single full word last: marker word needed, three cycles
    push_model(4, 'h70);
    send_word(32'h7071_7273, 1'b1, 3'd4);
    lat_check("lat_n4", 3);
    drain();

    // Reset after 7 words discards them; following "abc" is unaffected
    for (int k = 0; k < 7; k++) send_word(32'hDEAD_0000 + k, 1'b0, 3'd2);
    reset_check();
    push_model(3, 'h61);
    send_word(32'h6162_6300, 1'b1, 3'd3);
    lat_check("lat_abc_after_rst", 2);
    drain();

    for (int i = 0; i < 8; i++) begin
      stall = tbl[i].stall;
      n0 = nblk;
      push_model(tbl[i].len, tbl[i].base);
      send_msg(tbl[i].len, tbl[i].base, tbl[i].over);
      idle_in();
      drain();
      chk($sformatf("nblk_len%0d", tbl[i].len), 512'(nblk - n0), 512'(tbl[i].nblk));
    end

    chk("queue_empty", 512'(q.size()), 512'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
